// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin encodings and values, and the payout FSM states.
package vm_pkg;

  localparam logic [1:0] MOEDA_NENHUMA = 2'b00;
  localparam logic [1:0] MOEDA_25      = 2'b01;
  localparam logic [1:0] MOEDA_50      = 2'b10;
  localparam logic [1:0] MOEDA_100     = 2'b11;

  localparam logic [7:0] VALOR_25  = 8'd25;
  localparam logic [7:0] VALOR_50  = 8'd50;
  localparam logic [7:0] VALOR_100 = 8'd100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_DONE,
    ST_FAIL
  } estado_t;

  function automatic logic [7:0] valor_moeda(input logic [1:0] tipo);
    case (tipo)
      MOEDA_25:  valor_moeda = VALOR_25;
      MOEDA_50:  valor_moeda = VALOR_50;
      MOEDA_100: valor_moeda = VALOR_100;
      default:   valor_moeda = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/seletor_moeda.sv
// Greedy coin chooser: largest denomination that fits the remainder and is still in stock.
module seletor_moeda
  import vm_pkg::*;
(
  input  logic [7:0] restante_i,
  input  logic [7:0] cont_25_i,
  input  logic [7:0] cont_50_i,
  input  logic [7:0] cont_100_i,
  output logic [1:0] tipo_o,
  output logic       achou_o
);

  always_comb begin
    tipo_o  = MOEDA_NENHUMA;
    achou_o = 1'b0;
    if (restante_i >= VALOR_100 && cont_100_i != 8'd0) begin
      tipo_o  = MOEDA_100;
      achou_o = 1'b1;
    end else if (restante_i >= VALOR_50 && cont_50_i != 8'd0) begin
      tipo_o  = MOEDA_50;
      achou_o = 1'b1;
    end else if (restante_i >= VALOR_25 && cont_25_i != 8'd0) begin
      tipo_o  = MOEDA_25;
      achou_o = 1'b1;
    end
  end

endmodule

// File: rtl/dispensador_troco.sv
// Sequenced change payout: one coin per valid/ack handshake, largest first,
// reporting the updated wallet or a shortfall when exact change is impossible.
module dispensador_troco
  import vm_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] valor_troco,
  input  logic [7:0] carteira_25_in,
  input  logic [7:0] carteira_50_in,
  input  logic [7:0] carteira_100_in,
  input  logic       moeda_ack,
  output logic       moeda_valid,
  output logic [1:0] moeda_tipo,
  output logic       ocupado,
  output logic       concluido,
  output logic       falha,
  output logic [7:0] restante,
  output logic [7:0] moedas_25_out,
  output logic [7:0] moedas_50_out,
  output logic [7:0] moedas_100_out,
  output logic [3:0] n_moedas
);

  estado_t    estado_q, estado_d;
  logic [7:0] restante_q, restante_d;
  logic [7:0] c25_q, c25_d, c50_q, c50_d, c100_q, c100_d;
  logic [3:0] n_q, n_d;
  logic [1:0] tipo_q, tipo_d;
  logic [1:0] sel_tipo;
  logic       sel_achou;

  seletor_moeda u_seletor (
    .restante_i (restante_q),
    .cont_25_i  (c25_q),
    .cont_50_i  (c50_q),
    .cont_100_i (c100_q),
    .tipo_o     (sel_tipo),
    .achou_o    (sel_achou)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= ST_IDLE;
      restante_q <= 8'd0;
      c25_q      <= 8'd0;
      c50_q      <= 8'd0;
      c100_q     <= 8'd0;
      n_q        <= 4'd0;
      tipo_q     <= MOEDA_NENHUMA;
    end else begin
      estado_q   <= estado_d;
      restante_q <= restante_d;
      c25_q      <= c25_d;
      c50_q      <= c50_d;
      c100_q     <= c100_d;
      n_q        <= n_d;
      tipo_q     <= tipo_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    restante_d = restante_q;
    c25_d      = c25_q;
    c50_d      = c50_q;
    c100_d     = c100_q;
    n_d        = n_q;
    tipo_d     = tipo_q;
    case (estado_q)
      ST_IDLE: begin
        if (iniciar) begin
          restante_d = valor_troco;
          c25_d      = carteira_25_in;
          c50_d      = carteira_50_in;
          c100_d     = carteira_100_in;
          n_d        = 4'd0;
          estado_d   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (restante_q == 8'd0) begin
          estado_d = ST_DONE;
        end else if (sel_achou) begin
          tipo_d   = sel_tipo;
          estado_d = ST_EJECT;
        end else begin
          estado_d = ST_FAIL;
        end
      end
      ST_EJECT: begin
        // The selector guaranteed remainder >= coin value and count > 0, so no underflow.
        if (moeda_ack) begin
          restante_d = restante_q - valor_moeda(tipo_q);
          case (tipo_q)
            MOEDA_25:  c25_d  = c25_q - 8'd1;
            MOEDA_50:  c50_d  = c50_q - 8'd1;
            MOEDA_100: c100_d = c100_q - 8'd1;
            default:   ;
          endcase
          n_d      = n_q + 4'd1;
          tipo_d   = MOEDA_NENHUMA;
          estado_d = ST_SELECT;
        end
      end
      ST_DONE: estado_d = ST_IDLE;
      ST_FAIL: estado_d = ST_IDLE;
      default: estado_d = ST_IDLE;
    endcase
  end

  assign ocupado        = (estado_q != ST_IDLE);
  assign moeda_valid    = (estado_q == ST_EJECT);
  assign moeda_tipo     = moeda_valid ? tipo_q : MOEDA_NENHUMA;
  assign concluido      = (estado_q == ST_DONE);
  assign falha          = (estado_q == ST_FAIL);
  assign restante       = restante_q;
  assign moedas_25_out  = c25_q;
  assign moedas_50_out  = c50_q;
  assign moedas_100_out = c100_q;
  assign n_moedas       = n_q;

endmodule
